// File: rtl/dram_bank_sequencer.sv
// Closed-page single-bank DRAM access sequencer with behavioural row storage.
module dram_bank_sequencer #(
    parameter int unsigned TRCD_CYCLES = 8,
    parameter int unsigned TCL_CYCLES  = 8,
    parameter int unsigned TRP_CYCLES  = 8,
    parameter int unsigned TWR_CYCLES  = 7,
    parameter int unsigned BURST_LEN   = 1,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned NUM_ROWS    = 100,
    parameter int unsigned ADDRESS_LEN = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDRESS_LEN-1:0] req_row,
    output logic                   wr_beat_ready,
    input  logic [DATA_W-1:0]      wr_data,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   done,
    output logic                   err,
    output logic [31:0]            access_cnt
);

    localparam int unsigned TIMER_W = 8;
    localparam int unsigned ROW_IW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned BEAT_IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    // Timing values must fit the 8-bit state timer and be non-zero.
    if (TRCD_CYCLES < 1 || TRCD_CYCLES > 255 || TCL_CYCLES < 1 || TCL_CYCLES > 255 ||
        TRP_CYCLES < 1 || TRP_CYCLES > 255 || TWR_CYCLES < 1 || TWR_CYCLES > 255 ||
        BURST_LEN < 1 || BURST_LEN > 255 || ADDRESS_LEN < 1 || ADDRESS_LEN > 32 ||
        NUM_ROWS < 1) begin : g_param_check
        $error("dram_bank_sequencer: timing parameter or BURST_LEN out of range 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATE,
        S_CAS,
        S_BURST,
        S_WRITE_RECOVERY,
        S_PRECHARGE
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 we_q;
    logic [ADDRESS_LEN-1:0] row_q;
    logic                 fire_c;
    logic                 row_ok_c;
    logic [ROW_IW-1:0]    row_idx_c;

    logic [DATA_W-1:0] mem [NUM_ROWS][BURST_LEN];

    assign fire_c    = req_valid && (state_q == S_IDLE);
    assign row_ok_c  = 32'(req_row) < NUM_ROWS;
    assign row_idx_c = ROW_IW'(row_q);

    // Next-state and per-state cycle timer; timer restarts at 0 on every state entry.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + TIMER_W'(1);
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (fire_c && row_ok_c) state_d = S_ACTIVATE;
            end
            S_ACTIVATE: begin
                if (timer_q == TIMER_W'(TRCD_CYCLES - 1)) begin
                    state_d = S_CAS;
                    timer_d = '0;
                end
            end
            S_CAS: begin
                if (timer_q == TIMER_W'(TCL_CYCLES - 1)) begin
                    state_d = S_BURST;
                    timer_d = '0;
                end
            end
            S_BURST: begin
                if (timer_q == TIMER_W'(BURST_LEN - 1)) begin
                    state_d = we_q ? S_WRITE_RECOVERY : S_PRECHARGE;
                    timer_d = '0;
                end
            end
            S_WRITE_RECOVERY: begin
                if (timer_q == TIMER_W'(TWR_CYCLES - 1)) begin
                    state_d = S_PRECHARGE;
                    timer_d = '0;
                end
            end
            S_PRECHARGE: begin
                if (timer_q == TIMER_W'(TRP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // State, request latch and registered outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            we_q          <= 1'b0;
            row_q         <= '0;
            req_ready     <= 1'b1;
            wr_beat_ready <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            access_cnt    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            if (fire_c && row_ok_c) begin
                we_q  <= req_we;
                row_q <= req_row;
            end
            req_ready     <= (state_d == S_IDLE);
            wr_beat_ready <= (state_d == S_BURST) && we_q;
            rd_valid      <= (state_d == S_BURST) && !we_q;
            if ((state_d == S_BURST) && !we_q) begin
                rd_data <= mem[row_idx_c][BEAT_IW'(timer_d)];
            end
            done          <= (state_d == S_PRECHARGE) && (timer_d == TIMER_W'(TRP_CYCLES - 1));
            err           <= fire_c && !row_ok_c;
            if ((state_q == S_PRECHARGE) && (timer_q == TIMER_W'(TRP_CYCLES - 1))) begin
                access_cnt <= access_cnt + 32'd1;
            end
        end
    end

    // Row storage: written at the edge closing each write beat; never cleared.
    always_ff @(posedge clk) begin
        if (!rst && (state_q == S_BURST) && we_q) begin
            mem[row_idx_c][BEAT_IW'(timer_q)] <= wr_data;
        end
    end

endmodule

// File: tb/tb_dram_bank_sequencer.sv
// Self-checking bench: default instance plus a BURST_LEN=4 instance.
module tb_dram_bank_sequencer;

    localparam int TRCD = 8, TCL = 8, TRP = 8, TWR = 7;
    localparam int RD_FIRST  = TRCD + TCL + 1;
    localparam int RD_READY  = TRCD + TCL + 1 + TRP + 1;
    localparam int WR_READY  = TRCD + TCL + 1 + TWR + TRP + 1;
    localparam int B4_TWR = 3;
    localparam int B4_WR_READY = TRCD + TCL + 4 + B4_TWR + TRP + 1;
    localparam int B4_RD_READY = TRCD + TCL + 4 + TRP + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        rv0 = 0, rr0, we0 = 0, wbr0, rdv0, done0, err0;
    logic [9:0]  row0 = '0;
    logic [63:0] wd0 = '0, rdd0;
    logic [31:0] cnt0;

    logic        rv1 = 0, rr1, we1 = 0, wbr1, rdv1, done1, err1;
    logic [9:0]  row1 = '0;
    logic [63:0] wd1 = '0, rdd1;
    logic [31:0] cnt1;

    int passed = 0;
    int total  = 0;

    // Reference model: row contents and completed-access count.
    logic [63:0] model_mem [100];
    bit          model_known [100];
    int unsigned model_cnt = 0;

    // Observations from one access on the default instance.
    int obs_ready_at, obs_rdv_cnt, obs_rdv_first, obs_done_cnt, obs_done_at;
    int obs_err_cnt, obs_wbr_cnt;
    logic [63:0] obs_rdv_data;

    always #5 clk = ~clk;

    dram_bank_sequencer u_dut0 (
        .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_we(we0),
        .req_row(row0), .wr_beat_ready(wbr0), .wr_data(wd0), .rd_valid(rdv0),
        .rd_data(rdd0), .done(done0), .err(err0), .access_cnt(cnt0)
    );

    dram_bank_sequencer #(.BURST_LEN(4), .TWR_CYCLES(B4_TWR)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_we(we1),
        .req_row(row1), .wr_beat_ready(wbr1), .wr_data(wd1), .rd_valid(rdv1),
        .rd_data(rdd1), .done(done1), .err(err1), .access_cnt(cnt1)
    );

    // Run one request on the default instance; starts and ends at a negedge.
    task automatic run0(input bit we, input logic [9:0] row, input logic [63:0] data);
        rv0 = 1'b1; we0 = we; row0 = row; wd0 = data;
        obs_ready_at = -1; obs_rdv_cnt = 0; obs_rdv_first = -1; obs_done_cnt = 0;
        obs_done_at = -1; obs_err_cnt = 0; obs_wbr_cnt = 0; obs_rdv_data = '0;
        @(posedge clk);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 1) begin
                rv0 = 1'b0; row0 = 10'($urandom); we0 = 1'($urandom);
            end
            wd0 = (obs_wbr_cnt == 0) ? data : {$urandom, $urandom};
            if (rdv0) begin
                if (obs_rdv_cnt == 0) obs_rdv_first = n;
                obs_rdv_data = rdd0;
                obs_rdv_cnt++;
            end
            if (wbr0) obs_wbr_cnt++;
            if (done0) begin obs_done_cnt++; obs_done_at = n; end
            if (err0) obs_err_cnt++;
            if (rr0) begin obs_ready_at = n; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (rr0 !== 1'b1) $display("FAIL reset_ready: got %0b want 1", rr0); else passed++;
        total++; if (rdv0 !== 1'b0) $display("FAIL reset_rd_valid: got %0b want 0", rdv0); else passed++;
        total++; if (wbr0 !== 1'b0) $display("FAIL reset_wr_beat_ready: got %0b want 0", wbr0); else passed++;
        total++; if (done0 !== 1'b0 || err0 !== 1'b0) $display("FAIL reset_done_err: got %0b%0b want 00", done0, err0); else passed++;
        total++; if (cnt0 !== 32'd0) $display("FAIL reset_access_cnt: got %0d want 0", cnt0); else passed++;
        total++; if (rdd0 !== 64'd0) $display("FAIL reset_rd_data: got %0h want 0", rdd0); else passed++;
        total++; if (rr1 !== 1'b1 || cnt1 !== 32'd0) $display("FAIL reset_b4: got ready=%0b cnt=%0d want 1/0", rr1, cnt1); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        run0(1'b1, 10'd5, 64'hDEAD_BEEF_0123_4567);
        model_mem[5] = 64'hDEAD_BEEF_0123_4567; model_known[5] = 1'b1; model_cnt++;
        total++; if (obs_ready_at !== WR_READY) $display("FAIL wr_ready_latency: got %0d want %0d", obs_ready_at, WR_READY); else passed++;
        total++; if (obs_wbr_cnt !== 1) $display("FAIL wr_beat_count: got %0d want 1", obs_wbr_cnt); else passed++;
        total++; if (obs_done_cnt !== 1 || obs_done_at !== WR_READY - 1) $display("FAIL wr_done: got cnt=%0d at=%0d want 1 at %0d", obs_done_cnt, obs_done_at, WR_READY - 1); else passed++;
        run0(1'b0, 10'd5, 64'd0);
        model_cnt++;
        total++; if (obs_rdv_first !== RD_FIRST) $display("FAIL rd_latency: got %0d want %0d", obs_rdv_first, RD_FIRST); else passed++;
        total++; if (obs_rdv_data !== model_mem[5]) $display("FAIL rd_data_row5: got %0h want %0h", obs_rdv_data, model_mem[5]); else passed++;
        total++; if (obs_rdv_cnt !== 1 || obs_done_cnt !== 1) $display("FAIL rd_pulses: got rdv=%0d done=%0d want 1/1", obs_rdv_cnt, obs_done_cnt); else passed++;
        total++; if (obs_ready_at !== RD_READY) $display("FAIL rd_ready_latency: got %0d want %0d", obs_ready_at, RD_READY); else passed++;
        total++; if (cnt0 !== model_cnt) $display("FAIL access_cnt_2: got %0d want %0d", cnt0, model_cnt); else passed++;
        total++; if (rdd0 !== model_mem[5]) $display("FAIL rd_data_hold: got %0h want %0h", rdd0, model_mem[5]); else passed++;
    endtask

    task automatic test_invalid_row();
        int rdv_seen;
        logic [9:0] bad [2];
        bad[0] = 10'd100; bad[1] = 10'd1023;
        for (int i = 0; i < 2; i++) begin
            run0(1'b0, bad[i], 64'd0);
            total++; if (obs_err_cnt !== 1) $display("FAIL err_pulse: row=%0d got %0d want 1", bad[i], obs_err_cnt); else passed++;
            total++; if (obs_ready_at !== 1) $display("FAIL err_ready_stays: got %0d want 1", obs_ready_at); else passed++;
            rdv_seen = 0;
            for (int n = 0; n < 30; n++) begin
                @(negedge clk);
                if (rdv0 || done0 || err0 || !rr0) rdv_seen++;
            end
            total++; if (rdv_seen !== 0) $display("FAIL err_quiet: got %0d activity cycles want 0", rdv_seen); else passed++;
            total++; if (cnt0 !== model_cnt) $display("FAIL err_cnt_unchanged: got %0d want %0d", cnt0, model_cnt); else passed++;
        end
    endtask

    task automatic test_reset_mid_access();
        int act;
        rv0 = 1'b1; we0 = 1'b0; row0 = 10'd5;
        @(posedge clk);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) rv0 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_cnt = 0;
        total++; if (rr0 !== 1'b1) $display("FAIL midrst_idle: got ready=%0b want 1", rr0); else passed++;
        act = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rdv0 || done0) act++;
        end
        total++; if (act !== 0) $display("FAIL midrst_no_rdv_done: got %0d want 0", act); else passed++;
        total++; if (cnt0 !== 32'd0) $display("FAIL midrst_cnt: got %0d want 0", cnt0); else passed++;
        run0(1'b0, 10'd5, 64'd0);
        model_cnt++;
        total++; if (obs_rdv_data !== model_mem[5]) $display("FAIL midrst_storage_kept: got %0h want %0h", obs_rdv_data, model_mem[5]); else passed++;
    endtask

    task automatic test_random();
        bit we, ok;
        logic [9:0] row;
        logic [63:0] d;
        int sel, exp_ready;
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 9));
            row = (sel < 8) ? 10'(sel * 13) : 10'($urandom_range(100, 1023));
            we  = 1'($urandom_range(0, 1));
            d   = {$urandom, $urandom};
            ok  = (row < 10'd100);
            run0(we, row, d);
            exp_ready = !ok ? 1 : (we ? WR_READY : RD_READY);
            total++; if (obs_ready_at !== exp_ready) $display("FAIL rnd_ready[%0d]: got %0d want %0d", i, obs_ready_at, exp_ready); else passed++;
            total++; if (obs_err_cnt !== int'(!ok) || obs_done_cnt !== int'(ok)) $display("FAIL rnd_err_done[%0d]: got err=%0d done=%0d want %0d/%0d", i, obs_err_cnt, obs_done_cnt, !ok, ok); else passed++;
            total++; if (obs_rdv_cnt !== int'(ok && !we) || obs_wbr_cnt !== int'(ok && we)) $display("FAIL rnd_beats[%0d]: got rdv=%0d wbr=%0d", i, obs_rdv_cnt, obs_wbr_cnt); else passed++;
            if (ok && !we && model_known[row]) begin
                total++; if (obs_rdv_data !== model_mem[row] || obs_rdv_first !== RD_FIRST) $display("FAIL rnd_rdata[%0d]: row=%0d got %0h@%0d want %0h@%0d", i, row, obs_rdv_data, obs_rdv_first, model_mem[row], RD_FIRST); else passed++;
            end
            if (ok) begin
                model_cnt++;
                if (we) begin model_mem[row] = d; model_known[row] = 1'b1; end
            end
            total++; if (cnt0 !== model_cnt) $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, cnt0, model_cnt); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int second_fire, end_at, nrd;
        int rd_at [2];
        logic [63:0] rd_val [2];
        run0(1'b1, 10'd99, 64'hA5A5_0000_FFFF_1234);
        model_mem[99] = 64'hA5A5_0000_FFFF_1234; model_known[99] = 1'b1; model_cnt++;
        second_fire = -1; end_at = -1; nrd = 0;
        rd_at[0] = -1; rd_at[1] = -1; rd_val[0] = '0; rd_val[1] = '0;
        rv0 = 1'b1; we0 = 1'b0; row0 = 10'd5;
        @(posedge clk);
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (n == 1) row0 = 10'd99;
            if (second_fire > 0 && n == second_fire + 1) rv0 = 1'b0;
            if (rdv0 && nrd < 2) begin rd_at[nrd] = n; rd_val[nrd] = rdd0; nrd++; end
            if (rr0 && second_fire < 0) second_fire = n;
            else if (rr0 && second_fire > 0 && n > second_fire) begin end_at = n; break; end
        end
        rv0 = 1'b0;
        model_cnt += 2;
        total++; if (second_fire !== RD_READY) $display("FAIL b2b_second_fire: got %0d want %0d", second_fire, RD_READY); else passed++;
        total++; if (rd_at[0] !== RD_FIRST || rd_val[0] !== model_mem[5]) $display("FAIL b2b_first_read: got %0h@%0d want %0h@%0d", rd_val[0], rd_at[0], model_mem[5], RD_FIRST); else passed++;
        total++; if (rd_at[1] !== RD_READY + RD_FIRST || rd_val[1] !== model_mem[99]) $display("FAIL b2b_second_read: got %0h@%0d want %0h@%0d", rd_val[1], rd_at[1], model_mem[99], RD_READY + RD_FIRST); else passed++;
        total++; if (end_at !== 2 * RD_READY) $display("FAIL b2b_end: got %0d want %0d", end_at, 2 * RD_READY); else passed++;
        total++; if (cnt0 !== model_cnt) $display("FAIL b2b_cnt: got %0d want %0d", cnt0, model_cnt); else passed++;
    endtask

    task automatic test_cnt_wrap();
        @(negedge clk);
        force u_dut0.access_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release u_dut0.access_cnt;
        @(negedge clk);
        total++; if (cnt0 !== 32'hFFFF_FFFF) $display("FAIL wrap_preset: got %0h want ffffffff", cnt0); else passed++;
        run0(1'b0, 10'd5, 64'd0);
        total++; if (cnt0 !== 32'd0) $display("FAIL wrap_to_zero: got %0h want 0", cnt0); else passed++;
    endtask

    task automatic test_burst4();
        int k, ready_at, wbr_first, nrd;
        int rd_at [4];
        logic [63:0] rd_val [4];
        k = 0; ready_at = -1; wbr_first = -1;
        rv1 = 1'b1; we1 = 1'b1; row1 = 10'd99; wd1 = 64'd1;
        @(posedge clk);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 1) begin rv1 = 1'b0; row1 = 10'd3; we1 = 1'b0; end
            wd1 = 64'(k + 1);
            if (wbr1) begin if (k == 0) wbr_first = n; k++; end
            if (rr1) begin ready_at = n; break; end
        end
        total++; if (ready_at !== B4_WR_READY) $display("FAIL b4_wr_ready: got %0d want %0d", ready_at, B4_WR_READY); else passed++;
        total++; if (k !== 4 || wbr_first !== RD_FIRST) $display("FAIL b4_wr_beats: got %0d@%0d want 4@%0d", k, wbr_first, RD_FIRST); else passed++;
        nrd = 0; ready_at = -1;
        for (int i = 0; i < 4; i++) begin rd_at[i] = -1; rd_val[i] = '0; end
        rv1 = 1'b1; we1 = 1'b0; row1 = 10'd99;
        @(posedge clk);
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 1) rv1 = 1'b0;
            if (rdv1) begin
                if (nrd < 4) begin rd_at[nrd] = n; rd_val[nrd] = rdd1; end
                nrd++;
            end
            if (rr1) begin ready_at = n; break; end
        end
        total++; if (nrd !== 4) $display("FAIL b4_rd_count: got %0d want 4", nrd); else passed++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_at[i] !== RD_FIRST + i || rd_val[i] !== 64'(i + 1)) $display("FAIL b4_rd_beat%0d: got %0h@%0d want %0h@%0d", i, rd_val[i], rd_at[i], i + 1, RD_FIRST + i); else passed++;
        end
        total++; if (ready_at !== B4_RD_READY) $display("FAIL b4_rd_ready: got %0d want %0d", ready_at, B4_RD_READY); else passed++;
        total++; if (cnt1 !== 32'd2) $display("FAIL b4_cnt: got %0d want 2", cnt1); else passed++;
    endtask

    initial begin
        for (int i = 0; i < 100; i++) begin model_mem[i] = '0; model_known[i] = 1'b0; end
        test_reset();
        test_write_read();
        test_invalid_row();
        test_reset_mid_access();
        test_random();
        test_back_to_back();
        test_cnt_wrap();
        test_burst4();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", passed, total);
        $fatal(1);
    end

endmodule
